// File: rtl/rice_bus_pkg.sv
// Shared types for the rice bus arbiter: FSM state encoding and requester indices.
package rice_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        RESPONSE = 2'd2
    } rice_bus_arbiter_state;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_DATA  = 1;

endpackage

// File: rtl/rice_bus_if.sv
// Rice bus: one request channel and one response channel, each a valid/ready pair.
// Handshake: a beat moves on a rising edge where valid && ready; a raised valid stays up with stable payload until it moves.
interface rice_bus_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                      request_valid;
    logic                      request_ready;
    logic [ADDRESS_WIDTH-1:0]  address;
    logic                      write;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic                      response_valid;
    logic                      response_ready;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      error;

    modport master (
        output request_valid, address, write, write_data, strobe, response_ready,
        input  request_ready, response_valid, read_data, error
    );

    modport slave (
        input  request_valid, address, write, write_data, strobe, response_ready,
        output request_ready, response_valid, read_data, error
    );
endinterface

// File: rtl/rice_bus_rr_select.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// whichever requester did not win last time.
module rice_bus_rr_select
    import rice_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    // last_grant is the index of the previous winner: 0 = fetch, 1 = data.
    always_comb begin
        grant = req;
        if (&req) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/rice_bus_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memory port, keeping a
// single transaction outstanding and routing its response back to the owner.
module rice_bus_arbiter
    import rice_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rice_bus_if.slave             fetch_bus_if,
    rice_bus_if.slave             data_bus_if,
    rice_bus_if.master            memory_bus_if,
    output logic [1:0]            o_grant,
    output rice_bus_arbiter_state o_state
);

    rice_bus_arbiter_state state_q, state_d;
    logic [NUM_REQ-1:0]      owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]      req_vec;
    logic [NUM_REQ-1:0]      rr_grant;
    logic [NUM_REQ-1:0]      sel;
    logic                    req_xfer;
    logic                    rsp_xfer;
    logic [ADDRESS_WIDTH-1:0] sel_address;
    logic                    sel_write;
    logic [DATA_WIDTH-1:0]   sel_write_data;
    logic [DATA_WIDTH/8-1:0] sel_strobe;

    assign req_vec = {data_bus_if.request_valid, fetch_bus_if.request_valid};

    rice_bus_rr_select u_rr_select (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .grant      (rr_grant)
    );

    // The owner is fixed once a request is accepted or stalled; while in reset nobody is selected.
    always_comb begin
        sel = 2'b00;
        case (state_q)
            IDLE:              sel = rr_grant;
            REQUEST, RESPONSE: sel = owner_q;
            default:           sel = 2'b00;
        endcase
        if (!i_rst_n) begin
            sel = 2'b00;
        end
    end

    always_comb begin
        sel_address    = fetch_bus_if.address;
        sel_write      = fetch_bus_if.write;
        sel_write_data = fetch_bus_if.write_data;
        sel_strobe     = fetch_bus_if.strobe;
        if (sel[REQ_DATA]) begin
            sel_address    = data_bus_if.address;
            sel_write      = data_bus_if.write;
            sel_write_data = data_bus_if.write_data;
            sel_strobe     = data_bus_if.strobe;
        end
    end

    // request_ready never depends on response-channel signals.
    always_comb begin
        memory_bus_if.request_valid  = 1'b0;
        memory_bus_if.address        = sel_address;
        memory_bus_if.write          = sel_write;
        memory_bus_if.write_data     = sel_write_data;
        memory_bus_if.strobe         = sel_strobe;
        memory_bus_if.response_ready = 1'b0;
        fetch_bus_if.request_ready   = 1'b0;
        fetch_bus_if.response_valid  = 1'b0;
        fetch_bus_if.read_data       = '0;
        fetch_bus_if.error           = 1'b0;
        data_bus_if.request_ready    = 1'b0;
        data_bus_if.response_valid   = 1'b0;
        data_bus_if.read_data        = '0;
        data_bus_if.error            = 1'b0;
        if (state_q == RESPONSE) begin
            if (sel[REQ_FETCH]) begin
                fetch_bus_if.response_valid  = memory_bus_if.response_valid;
                fetch_bus_if.read_data       = memory_bus_if.read_data;
                fetch_bus_if.error           = memory_bus_if.error;
                memory_bus_if.response_ready = fetch_bus_if.response_ready;
            end
            if (sel[REQ_DATA]) begin
                data_bus_if.response_valid   = memory_bus_if.response_valid;
                data_bus_if.read_data        = memory_bus_if.read_data;
                data_bus_if.error            = memory_bus_if.error;
                memory_bus_if.response_ready = data_bus_if.response_ready;
            end
        end else begin
            memory_bus_if.request_valid = |(sel & req_vec);
            fetch_bus_if.request_ready  = sel[REQ_FETCH] & memory_bus_if.request_ready;
            data_bus_if.request_ready   = sel[REQ_DATA] & memory_bus_if.request_ready;
        end
    end

    assign req_xfer = memory_bus_if.request_valid & memory_bus_if.request_ready;
    assign rsp_xfer = (state_q == RESPONSE) & memory_bus_if.response_valid
                    & memory_bus_if.response_ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|sel) begin
                    owner_d = sel;
                    if (req_xfer) begin
                        state_d      = RESPONSE;
                        last_grant_d = sel[REQ_DATA];
                    end else begin
                        state_d = REQUEST;
                    end
                end
            end
            REQUEST: begin
                if (req_xfer) begin
                    state_d      = RESPONSE;
                    last_grant_d = owner_q[REQ_DATA];
                end
            end
            RESPONSE: begin
                if (rsp_xfer) begin
                    state_d = IDLE;
                    owner_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 2'b00;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign o_grant = sel;
    assign o_state = state_q;

    // A stalled owner must keep its request raised until the memory accepts it.
    locked_request_held: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (state_q == REQUEST) |-> |(owner_q & req_vec)
    );

endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Directed bench for rice_bus_arbiter: requester drivers, a memory model and a
// queue-based scoreboard checking every request and response handshake.
`timescale 1ns/1ps
module tb_rice_bus_arbiter;
    import rice_bus_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int REQ_W = 2 + 1 + SW + AW + DW;
    localparam int RSP_W = 1 + DW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rice_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) fetch_if ();
    rice_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) data_if ();
    rice_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    logic [1:0]            grant;
    rice_bus_arbiter_state state;

    rice_bus_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .fetch_bus_if  (fetch_if),
        .data_bus_if   (data_if),
        .memory_bus_if (mem_if),
        .o_grant       (grant),
        .o_state       (state)
    );

    // ---------------- scoreboard state ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [REQ_W-1:0] exp_req_q[$];
    logic [RSP_W-1:0] f_exp_q[$];
    logic [RSP_W-1:0] d_exp_q[$];

    logic [DW-1:0] mem_data [logic [AW-1:0]];
    logic          mem_err  [logic [AW-1:0]];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [1:0] g, input logic wr, input logic [SW-1:0] strb,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        exp_req_q.push_back({g, wr, strb, addr, wdata});
    endtask

    // ---------------- memory model ----------------
    // Answers one cycle after accepting a request, holding the response until taken.
    initial begin : memory_model
        logic          req_seen;
        logic          rsp_seen;
        logic [AW-1:0] req_addr;
        mem_if.response_valid = 1'b0;
        mem_if.read_data      = '0;
        mem_if.error          = 1'b0;
        forever begin
            @(negedge clk);
            req_seen = rst_n && mem_if.request_valid && mem_if.request_ready;
            rsp_seen = rst_n && mem_if.response_valid && mem_if.response_ready;
            req_addr = mem_if.address;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_if.response_valid = 1'b0;
            end else begin
                if (rsp_seen) mem_if.response_valid = 1'b0;
                if (req_seen) begin
                    mem_if.response_valid = 1'b1;
                    mem_if.read_data      = mem_data[req_addr];
                    mem_if.error          = mem_err[req_addr];
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input int port, input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                        input logic [DW-1:0] rdata, input logic err, input bit expect_rsp);
        bit done = 1'b0;
        if (expect_rsp) begin
            if (port == 0) f_exp_q.push_back({err, rdata});
            else           d_exp_q.push_back({err, rdata});
        end
        if (port == 0) begin
            fetch_if.request_valid = 1'b1;
            fetch_if.address       = addr;
            fetch_if.write         = wr;
            fetch_if.write_data    = wdata;
            fetch_if.strobe        = strb;
        end else begin
            data_if.request_valid = 1'b1;
            data_if.address       = addr;
            data_if.write         = wr;
            data_if.write_data    = wdata;
            data_if.strobe        = strb;
        end
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (port == 0) done = fetch_if.request_ready;
            else           done = data_if.request_ready;
        end
        if (!done) check("req_handshake_timeout", 0, 1);
        step();
        if (port == 0) fetch_if.request_valid = 1'b0;
        else           data_if.request_valid  = 1'b0;
    endtask

    // ---------------- monitor ----------------
    task automatic monitor();
        logic [REQ_W-1:0] er;
        logic [RSP_W-1:0] es;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_if.request_valid && mem_if.request_ready) begin
                    if (exp_req_q.size() == 0) fail("mem_req_unexpected");
                    else begin
                        er = exp_req_q.pop_front();
                        check("mem_req", {grant, mem_if.write, mem_if.strobe, mem_if.address, mem_if.write_data}, er);
                    end
                end
                if (fetch_if.response_valid && fetch_if.response_ready) begin
                    if (f_exp_q.size() == 0) fail("fetch_rsp_unexpected");
                    else begin
                        es = f_exp_q.pop_front();
                        check("fetch_rsp", {fetch_if.error, fetch_if.read_data}, es);
                    end
                end
                if (data_if.response_valid && data_if.response_ready) begin
                    if (d_exp_q.size() == 0) fail("data_rsp_unexpected");
                    else begin
                        es = d_exp_q.pop_front();
                        check("data_rsp", {data_if.error, data_if.read_data}, es);
                    end
                end
                if (fetch_if.response_valid && data_if.response_valid) fail("both_rsp_valid");
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        fetch_if.request_valid  = 1'b0;
        fetch_if.address        = '0;
        fetch_if.write          = 1'b0;
        fetch_if.write_data     = '0;
        fetch_if.strobe         = '0;
        fetch_if.response_ready = 1'b1;
        data_if.request_valid   = 1'b0;
        data_if.address         = '0;
        data_if.write           = 1'b0;
        data_if.write_data      = '0;
        data_if.strobe          = '0;
        data_if.response_ready  = 1'b1;
        mem_if.request_ready    = 1'b1;

        fork
            monitor();
        join_none

        // Reset: requests raised during reset must not leak through.
        repeat (3) step();
        fetch_if.request_valid = 1'b1;
        data_if.request_valid  = 1'b1;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_state", state, IDLE);
        check("rst_mem_req_valid", mem_if.request_valid, 1'b0);
        check("rst_mem_rsp_ready", mem_if.response_ready, 1'b0);
        check("rst_fetch_req_ready", fetch_if.request_ready, 1'b0);
        check("rst_data_req_ready", data_if.request_ready, 1'b0);
        fetch_if.request_valid = 1'b0;
        data_if.request_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fetch-only read returning 0xDEADBEEF.
        mem_data[32'h100] = 32'hDEADBEEF;
        mem_err[32'h100]  = 1'b0;
        expect_req(2'b01, 1'b0, 4'hF, 32'h100, 32'h0);
        fork
            send(0, 32'h100, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1);
            begin
                @(negedge clk);
                check("fetch_only_grant_c1", grant, 2'b01);
                check("fetch_only_data_rsp_c1", data_if.response_valid, 1'b0);
                @(negedge clk);
                check("fetch_only_grant_c2", grant, 2'b01);
                check("fetch_only_state_c2", state, RESPONSE);
                check("fetch_only_data_rsp_c2", data_if.response_valid, 1'b0);
                @(negedge clk);
                check("fetch_only_grant_c3", grant, 2'b00);
                check("fetch_only_state_c3", state, IDLE);
            end
        join
        step();

        // Simultaneous back-to-back requests after reset: data first, then alternate.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            mem_data[32'h2000 + 4*i] = 32'hD0000000 + i;
            mem_err[32'h2000 + 4*i]  = 1'b0;
            mem_data[32'h1000 + 4*i] = 32'hF0000000 + i;
            mem_err[32'h1000 + 4*i]  = 1'b0;
            expect_req(2'b10, 1'b1, 4'hF, 32'h2000 + 4*i, 32'h5A000000 + i);
            expect_req(2'b01, 1'b0, 4'hF, 32'h1000 + 4*i, 32'h0);
        end
        fork
            for (int i = 0; i < 4; i++)
                send(1, 32'h2000 + 4*i, 1'b1, 32'h5A000000 + i, 4'hF, 32'hD0000000 + i, 1'b0, 1'b1);
            for (int i = 0; i < 4; i++)
                send(0, 32'h1000 + 4*i, 1'b0, 32'h0, 4'hF, 32'hF0000000 + i, 1'b0, 1'b1);
        join
        repeat (3) step();
        check("rr_all_requests_seen", exp_req_q.size(), 0);

        // Memory stalls 3 cycles with fetch owning; data arrives in cycle 2.
        mem_data[32'h300] = 32'h33333333;
        mem_err[32'h300]  = 1'b0;
        mem_data[32'h400] = 32'h44444444;
        mem_err[32'h400]  = 1'b0;
        expect_req(2'b01, 1'b0, 4'hF, 32'h300, 32'h0);
        expect_req(2'b10, 1'b0, 4'hF, 32'h400, 32'h0);
        mem_if.request_ready = 1'b0;
        fork
            send(0, 32'h300, 1'b0, 32'h0, 4'hF, 32'h33333333, 1'b0, 1'b1);
            begin
                step();
                send(1, 32'h400, 1'b0, 32'h0, 4'hF, 32'h44444444, 1'b0, 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_grant", grant, 2'b01);
                    check("stall_data_req_ready", data_if.request_ready, 1'b0);
                    if (k > 0) check("stall_state", state, REQUEST);
                end
                step();
                mem_if.request_ready = 1'b1;
                @(negedge clk);
                check("stall_release_grant", grant, 2'b01);
                check("stall_release_data_req_ready", data_if.request_ready, 1'b0);
            end
        join
        repeat (3) step();

        // Data store with partial strobe and an error response.
        mem_data[32'h500] = 32'h0;
        mem_err[32'h500]  = 1'b1;
        expect_req(2'b10, 1'b1, 4'b0011, 32'h500, 32'h12345678);
        fork
            send(1, 32'h500, 1'b1, 32'h12345678, 4'b0011, 32'h0, 1'b1, 1'b1);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("err_fetch_rsp_valid", fetch_if.response_valid, 1'b0);
                    check("err_fetch_error", fetch_if.error, 1'b0);
                end
            end
        join
        step();

        // Owner withholds response_ready for 2 cycles.
        mem_data[32'h600] = 32'hCAFEF00D;
        mem_err[32'h600]  = 1'b0;
        expect_req(2'b01, 1'b0, 4'hF, 32'h600, 32'h0);
        fetch_if.response_ready = 1'b0;
        fork
            send(0, 32'h600, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1);
            begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("bp_mem_rsp_ready", mem_if.response_ready, 1'b0);
                    check("bp_state", state, RESPONSE);
                    check("bp_fetch_rsp_valid", fetch_if.response_valid, 1'b1);
                end
                step();
                fetch_if.response_ready = 1'b1;
                @(negedge clk);
                check("bp_mem_rsp_ready_release", mem_if.response_ready, 1'b1);
                @(negedge clk);
                check("bp_state_after", state, IDLE);
            end
        join
        step();

        // Reset while a response is pending; it must be dropped.
        mem_data[32'h700] = 32'h11111111;
        mem_err[32'h700]  = 1'b0;
        expect_req(2'b01, 1'b0, 4'hF, 32'h700, 32'h0);
        fetch_if.response_ready = 1'b0;
        fork
            send(0, 32'h700, 1'b0, 32'h0, 4'hF, 32'h11111111, 1'b0, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                check("mid_rst_state_before", state, RESPONSE);
                #2;
                rst_n = 1'b0;
                #1;
                check("mid_rst_grant", grant, 2'b00);
                check("mid_rst_state", state, IDLE);
                check("mid_rst_fetch_rsp_valid", fetch_if.response_valid, 1'b0);
                check("mid_rst_mem_rsp_ready", mem_if.response_ready, 1'b0);
                check("mid_rst_mem_req_valid", mem_if.request_valid, 1'b0);
                check("mid_rst_fetch_req_ready", fetch_if.request_ready, 1'b0);
            end
        join
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        fetch_if.response_ready = 1'b1;
        step();
        @(negedge clk);
        check("post_rst_fetch_rsp_valid", fetch_if.response_valid, 1'b0);
        step();

        mem_data[32'h800] = 32'h88888888;
        mem_err[32'h800]  = 1'b0;
        mem_data[32'h900] = 32'h99999999;
        mem_err[32'h900]  = 1'b0;
        expect_req(2'b10, 1'b0, 4'hF, 32'h900, 32'h0);
        expect_req(2'b01, 1'b0, 4'hF, 32'h800, 32'h0);
        fork
            send(1, 32'h900, 1'b0, 32'h0, 4'hF, 32'h99999999, 1'b0, 1'b1);
            send(0, 32'h800, 1'b0, 32'h0, 4'hF, 32'h88888888, 1'b0, 1'b1);
        join

        // Drain and report.
        for (int c = 0; c < 100; c++) begin
            if (exp_req_q.size() == 0 && f_exp_q.size() == 0 && d_exp_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("final_req_queue_empty", exp_req_q.size(), 0);
        check("final_fetch_queue_empty", f_exp_q.size(), 0);
        check("final_data_queue_empty", d_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
